// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle fanned out from vga_timing_gen to renderers and the colour mux.
// frame_count is present only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hsync, vsync, line_start, frame_start, frame_count
    );
    modport slave (
        input DrawX, DrawY, blank, hsync, vsync, line_start, frame_start, frame_count
    );
`else
    modport master (
        output DrawX, DrawY, blank, hsync, vsync, line_start, frame_start
    );
    modport slave (
        input DrawX, DrawY, blank, hsync, vsync, line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel/line counters, blank, line/frame strobes and delayed syncs.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   SYNC_DELAY  = 2
) (
    input logic              vga_clk,
    input logic              reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_raw;
    logic       vsync_raw;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Sync as seen at the counters; the delay line below realigns it with registered RGB.
    always_comb begin
        hsync_raw = ~SYNC_ACTIVE;
        vsync_raw = ~SYNC_ACTIVE;
        if (hc_q >= H_SYNC_START && hc_q < H_SYNC_END) begin
            hsync_raw = SYNC_ACTIVE;
        end
        if (vc_q >= V_SYNC_START && vc_q < V_SYNC_END) begin
            vsync_raw = SYNC_ACTIVE;
        end
    end

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
    assign vga.line_start  = (hc_q == 10'd0);
    assign vga.frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.hsync = hsync_raw;
            assign vga.vsync = vsync_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d    = hs_pipe_q;
                vs_pipe_d    = vs_pipe_q;
                hs_pipe_d[0] = hsync_raw;
                vs_pipe_d[0] = vsync_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_pipe_d[i] = hs_pipe_q[i-1];
                    vs_pipe_d[i] = vs_pipe_q[i-1];
                end
            end

            // Flushing every stage to idle means a reset can never leave a partial pulse in flight.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
                    vs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign vga.hsync = hs_pipe_q[SYNC_DELAY-1];
            assign vga.vsync = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (hc_q == H_LAST && vc_q == V_LAST) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.frame_count = frame_count_q;
`else
    // No frame counter in this build.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (32x19) so whole frames stay short.
// A second instance checks the zero-delay, active-high sync configuration.
module tb_vga_timing_gen;

    localparam int HV = 16, HFP = 4, HS = 8, HBP = 4;
    localparam int VV = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HV + HFP + HS + HBP;   // 32
    localparam int VT = VV + VFP + VS + VBP;   // 19
    localparam int FRAME = HT * VT;            // 608
    localparam int DLY = 2;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen_if vif ();
    vga_timing_gen_if vif0 ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE(1'b0), .SYNC_DELAY(DLY)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (vif)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE(1'b1), .SYNC_DELAY(0)
    ) dut0 (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (vif0)
    );

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic wait_pos(input int x, input int y);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (int'(vif.DrawX) == x && int'(vif.DrawY) == y) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL wait_pos: (%0d,%0d) never reached, now at (%0d,%0d)", x, y, vif.DrawX, vif.DrawY);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        tests_run++;
        if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", vif.DrawX, vif.DrawY);
        end
        tests_run++;
        if ({vif.blank, vif.line_start, vif.frame_start} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_flags: blank/line/frame=%b%b%b expected 111", vif.blank, vif.line_start, vif.frame_start);
        end
        tests_run++;
        if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sync: hsync=%b vsync=%b expected 1 1", vif.hsync, vif.vsync);
        end
        step(1);
        tests_run++;
        if (vif.DrawX !== 10'd1 || vif.frame_start !== 1'b0 || vif.line_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_clock: DrawX=%0d frame_start=%b line_start=%b expected 1 0 0", vif.DrawX, vif.frame_start, vif.line_start);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_hblank();
        wait_pos(HV - 1, 0);
        tests_run++;
        if (vif.blank !== 1'b1) begin
            tests_failed++;
            $display("FAIL hblank_last_visible: blank=%b expected 1", vif.blank);
        end
        step(1);
        tests_run++;
        if (vif.DrawX !== 10'(HV) || vif.blank !== 1'b0) begin
            tests_failed++;
            $display("FAIL hblank_first_hidden: DrawX=%0d blank=%b expected %0d 0", vif.DrawX, vif.blank, HV);
        end
        wait_pos(HT - 1, 0);
        step(1);
        tests_run++;
        if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd1 || vif.line_start !== 1'b1 || vif.frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL line_wrap: (%0d,%0d) line_start=%b frame_start=%b expected (0,1) 1 0",
                     vif.DrawX, vif.DrawY, vif.line_start, vif.frame_start);
        end
        $display("[TB] test_hblank done");
    endtask

    task automatic test_hsync_line();
        int hc;
        logic exp_d, exp_0;
        int low_cnt = 0;
        wait_pos(0, 1);
        for (int i = 0; i < HT; i++) begin
            hc    = int'(vif.DrawX);
            exp_d = (hc >= HV + HFP + DLY && hc < HV + HFP + HS + DLY) ? 1'b0 : 1'b1;
            exp_0 = (hc >= HV + HFP && hc < HV + HFP + HS) ? 1'b1 : 1'b0;
            if (vif.hsync == 1'b0) low_cnt++;
            tests_run++;
            if (vif.hsync !== exp_d) begin
                tests_failed++;
                $display("FAIL hsync_delayed hc=%0d: got %b expected %b", hc, vif.hsync, exp_d);
            end
            tests_run++;
            if (vif0.hsync !== exp_0) begin
                tests_failed++;
                $display("FAIL hsync_nodelay hc=%0d: got %b expected %b", hc, vif0.hsync, exp_0);
            end
            step(1);
        end
        tests_run++;
        if (low_cnt != HS) begin
            tests_failed++;
            $display("FAIL hsync_width: got %0d clocks expected %0d", low_cnt, HS);
        end
        $display("[TB] test_hsync_line done");
    endtask

    task automatic test_vblank();
        int bad = 0;
        wait_pos(0, VV - 1);
        tests_run++;
        if (vif.blank !== 1'b1) begin
            tests_failed++;
            $display("FAIL vblank_last_line: blank=%b expected 1", vif.blank);
        end
        wait_pos(0, VV);
        for (int i = 0; i < FRAME && vif.DrawY != 10'd0; i++) begin
            if (vif.blank !== 1'b0) bad++;
            step(1);
        end
        tests_run++;
        if (bad != 0 || vif.DrawY !== 10'd0) begin
            tests_failed++;
            $display("FAIL vblank_region: %0d visible cycles, DrawY=%0d expected 0 and 0", bad, vif.DrawY);
        end
        tests_run++;
        if (vif.blank !== 1'b1 || vif.frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_top: blank=%b frame_start=%b expected 1 1", vif.blank, vif.frame_start);
        end
        $display("[TB] test_vblank done");
    endtask

    task automatic test_vsync_frame();
        int v_low = 0, h_low = 0, v0_high = 0;
        int fx = -1, fy = -1, lx = -1, ly = -1, f0x = -1, f0y = -1;
        wait_pos(0, 0);
        for (int i = 0; i < FRAME; i++) begin
            if (vif.vsync == 1'b0) begin
                if (fx < 0) begin fx = int'(vif.DrawX); fy = int'(vif.DrawY); end
                lx = int'(vif.DrawX);
                ly = int'(vif.DrawY);
                v_low++;
            end
            if (vif.hsync == 1'b0) h_low++;
            if (vif0.vsync == 1'b1) begin
                if (f0x < 0) begin f0x = int'(vif0.DrawX); f0y = int'(vif0.DrawY); end
                v0_high++;
            end
            step(1);
        end
        tests_run++;
        if (v_low != VS * HT) begin
            tests_failed++;
            $display("FAIL vsync_width: got %0d clocks expected %0d", v_low, VS * HT);
        end
        tests_run++;
        if (fx != DLY || fy != VV + VFP) begin
            tests_failed++;
            $display("FAIL vsync_start: got (%0d,%0d) expected (%0d,%0d)", fx, fy, DLY, VV + VFP);
        end
        tests_run++;
        if (lx != DLY - 1 || ly != VV + VFP + VS) begin
            tests_failed++;
            $display("FAIL vsync_end: got (%0d,%0d) expected (%0d,%0d)", lx, ly, DLY - 1, VV + VFP + VS);
        end
        tests_run++;
        if (h_low != HS * VT) begin
            tests_failed++;
            $display("FAIL hsync_per_frame: got %0d expected %0d", h_low, HS * VT);
        end
        tests_run++;
        if (v0_high != VS * HT || f0x != 0 || f0y != VV + VFP) begin
            tests_failed++;
            $display("FAIL vsync_nodelay: got %0d clocks from (%0d,%0d) expected %0d from (0,%0d)",
                     v0_high, f0x, f0y, VS * HT, VV + VFP);
        end
        $display("[TB] test_vsync_frame done");
    endtask

    task automatic test_frame_period();
        int period = -1;
        wait_pos(5, 3);
        for (int i = 0; i < 2 * FRAME && vif.frame_start !== 1'b1; i++) step(1);
        step(1);
        for (int i = 1; i <= 2 * FRAME; i++) begin
            if (vif.frame_start === 1'b1) begin
                period = i;
                break;
            end
            step(1);
        end
        tests_run++;
        if (period != FRAME) begin
            tests_failed++;
            $display("FAIL frame_period: got %0d clocks expected %0d", period, FRAME);
        end
        $display("[TB] test_frame_period done");
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        wait_pos(HV + HFP + 4, 7);
        tests_run++;
        if (vif.hsync !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset_hsync: got %b expected 0", vif.hsync);
        end
        reset = 1'b1;
        step(1);
        tests_run++;
        if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_h: (%0d,%0d) hsync=%b vsync=%b expected (0,0) 1 1", vif.DrawX, vif.DrawY, vif.hsync, vif.vsync);
        end
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) bad++;
            step(1);
        end
        tests_run++;
        if (bad != 0 || vif.DrawX !== 10'd4) begin
            tests_failed++;
            $display("FAIL post_reset_sync: %0d active cycles, DrawX=%0d expected 0 and 4", bad, vif.DrawX);
        end
        wait_pos(5, VV + VFP);
        step(DLY);
        tests_run++;
        if (vif.vsync !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset_vsync: got %b expected 0", vif.vsync);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tests_run++;
        if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0 || vif.vsync !== 1'b1 || vif.hsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_v: (%0d,%0d) hsync=%b vsync=%b expected (0,0) 1 1", vif.DrawX, vif.DrawY, vif.hsync, vif.vsync);
        end
        $display("[TB] test_reset_mid_frame done");
    endtask

`ifdef VGA_FRAME_COUNT_EN
    task automatic test_frame_count();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tests_run++;
        if (vif.frame_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL frame_count_reset: got %0d expected 0", vif.frame_count);
        end
        step(3 * FRAME - 1);
        tests_run++;
        if (vif.frame_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL frame_count_before: got %0d expected 2", vif.frame_count);
        end
        step(1);
        tests_run++;
        if (vif.frame_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL frame_count_3: got %0d expected 3", vif.frame_count);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tests_run++;
        if (vif.frame_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL frame_count_rereset: got %0d expected 0", vif.frame_count);
        end
        $display("[TB] test_frame_count done");
    endtask
`endif

    initial begin
        @(negedge vga_clk);
        test_reset();
        test_hblank();
        test_hsync_line();
        test_vblank();
        test_vsync_frame();
        test_frame_period();
        test_reset_mid_frame();
`ifdef VGA_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
